// File: rtl/aw_job_scheduler_pkg.sv
// Shared types and helpers for the AW job scheduler.
// State encoding, BRESP constant and width helpers.
package aw_job_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    DONE
  } State_t;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aw_job_scheduler_rr_arbiter.sv
// Combinational round-robin priority rotate.
// First asserted request at or after ptr wins.
module rr_arbiter
  import aw_job_scheduler_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_id
);

  localparam int SW = IW + 1;

  logic [SW-1:0] pos;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    found      = 1'b0;
    pos        = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      idx = pos[IW-1:0];
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = idx;
      end
    end
  end

endmodule

// File: rtl/aw_job_scheduler.sv
// Round-robin job scheduler sharing one AXI AW engine.
// Optional stats: define AW_JOB_SCHEDULER_STATS_EN.
module aw_job_scheduler
  import aw_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int BTT_WIDTH       = 23,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BTT_WIDTH-1:0]  req_btt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          eng_start,
  output logic [ADDR_WIDTH-1:0]         eng_start_addr,
  output logic [BTT_WIDTH-1:0]          eng_btt,
  output logic                          eng_enable,
  input  logic                          eng_new_transaction,
  input  logic                          eng_last_transaction,
  input  logic                          bvalid,
  input  logic                          bready,
  input  logic [1:0]                    bresp
`ifdef AW_JOB_SCHEDULER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         job_count,
  output logic [31:0]                   beat_stall_cycles
`endif
);

  localparam int IW = id_w(NUM_REQ);
  localparam int OW = cnt_w(MAX_OUTSTANDING);

  State_t state, state_n;

  logic [IW-1:0]         ptr, gid, arb_id;
  logic [NUM_REQ-1:0]    arb_oh;
  logic [OW-1:0]         outstanding, out_n;
  logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [BTT_WIDTH-1:0]  btt_q, sel_btt;
  logic                  last_seen, last_now;
  logic                  err_sticky;
  logic                  grant, b_hs, b_dec;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (arb_oh),
    .gnt_id     (arb_id)
  );

  always_comb begin
    sel_addr = '0;
    sel_btt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_id == IW'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_btt  = req_btt[i*BTT_WIDTH +: BTT_WIDTH];
      end
    end
  end

  assign grant    = (state == IDLE) && |req_valid && !rst;
  assign b_hs     = bvalid && bready;
  assign b_dec    = b_hs && (outstanding != '0);
  assign last_now = last_seen ||
                    (eng_new_transaction && eng_last_transaction);

  // Simultaneous AW and B leave the count unchanged
  always_comb begin
    unique case ({eng_new_transaction, b_dec})
      2'b10:   out_n = outstanding + OW'(1);
      2'b01:   out_n = outstanding - OW'(1);
      default: out_n = outstanding;
    endcase
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    done      = '0;
    err       = '0;
    eng_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          req_ready = arb_oh;
          state_n   = (sel_btt == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_n   = BUSY;
      end
      BUSY: begin
        if (last_now && out_n == '0) state_n = DONE;
      end
      DONE: begin
        done[gid] = 1'b1;
        err[gid]  = err_sticky;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gid         <= '0;
      addr_q      <= '0;
      btt_q       <= '0;
      outstanding <= '0;
      last_seen   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_n;
      outstanding <= out_n;
      if (grant) begin
        gid        <= arb_id;
        addr_q     <= sel_addr;
        btt_q      <= sel_btt;
        err_sticky <= 1'b0;
        last_seen  <= 1'b0;
      end
      if (state == BUSY) begin
        last_seen <= last_now;
        if (b_hs && bresp != BRESP_OKAY) err_sticky <= 1'b1;
      end
      if (state == DONE) begin
        ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + IW'(1);
      end
    end
  end

  assign busy           = (state != IDLE);
  assign grant_id       = gid;
  assign eng_start_addr = addr_q;
  assign eng_btt        = btt_q;
  assign eng_enable     = (state == BUSY) &&
                          (outstanding < OW'(MAX_OUTSTANDING));

  // A B response with nothing outstanding is a protocol error upstream
  b_underflow: assert property (
    @(posedge clk) disable iff (rst) !(b_hs && outstanding == '0)
  );

`ifdef AW_JOB_SCHEDULER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count         <= '0;
      beat_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) begin
          job_count[i*16 +: 16] <= job_count[i*16 +: 16] + 16'd1;
        end
      end
      if (state == BUSY && !eng_enable && beat_stall_cycles != '1) begin
        beat_stall_cycles <= beat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aw_job_scheduler.sv
// Directed bench for aw_job_scheduler.
// Job table plus throttle and reset sequences.
module tb_aw_job_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 23;

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  gid;
    logic [31:0] addr;
    logic [22:0] btt;
    int          n_aw;
    int          bad;
    logic        exp_err;
  } job_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*BW-1:0] req_btt;
  logic            eng_new_transaction;
  logic            eng_last_transaction;
  logic            bvalid, bready;
  logic [1:0]      bresp;

  logic [N-1:0]  req_ready, done, err;
  logic          busy, eng_start, eng_enable;
  logic [1:0]    grant_id;
  logic [AW-1:0] eng_start_addr;
  logic [BW-1:0] eng_btt;

  logic [N-1:0]  thr_ready, thr_done, thr_err;
  logic          thr_busy, thr_start, thr_en;
  logic [1:0]    thr_gid;
  logic [AW-1:0] thr_addr;
  logic [BW-1:0] thr_btt;

  int vecs  = 0;
  int fails = 0;

  job_t jobs [10];

  always #5 clk = ~clk;

  aw_job_scheduler #(.NUM_REQ(N)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_btt              (req_btt),
    .done                 (done),
    .err                  (err),
    .busy                 (busy),
    .grant_id             (grant_id),
    .eng_start            (eng_start),
    .eng_start_addr       (eng_start_addr),
    .eng_btt              (eng_btt),
    .eng_enable           (eng_enable),
    .eng_new_transaction  (eng_new_transaction),
    .eng_last_transaction (eng_last_transaction),
    .bvalid               (bvalid),
    .bready               (bready),
    .bresp                (bresp)
  );

  aw_job_scheduler #(.NUM_REQ(N), .MAX_OUTSTANDING(2)) u_thr (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (thr_ready),
    .req_addr             (req_addr),
    .req_btt              (req_btt),
    .done                 (thr_done),
    .err                  (thr_err),
    .busy                 (thr_busy),
    .grant_id             (thr_gid),
    .eng_start            (thr_start),
    .eng_start_addr       (thr_addr),
    .eng_btt              (thr_btt),
    .eng_enable           (thr_en),
    .eng_new_transaction  (eng_new_transaction),
    .eng_last_transaction (eng_last_transaction),
    .bvalid               (bvalid),
    .bready               (bready),
    .bresp                (bresp)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slices(input job_t j);
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = (i == int'(j.gid)) ? j.addr
                           : 32'hDEAD_0000 + 32'(i);
      req_btt[i*BW +: BW]  = (i == int'(j.gid)) ? j.btt
                           : 23'h7F000 + 23'(i);
    end
  endtask

  task automatic run_job(input job_t j);
    logic [3:0] oh;
    oh = 4'b0001 << j.gid;
    set_slices(j);
    req_valid = j.mask;
    #1;
    chk("req_ready", req_ready, oh);
    chk("idle_busy", busy, 0);
    cyc();
    chk("grant_id", grant_id, j.gid);
    chk("eng_start", eng_start, j.btt != 0);
    chk("start_addr", eng_start_addr, j.addr);
    chk("eng_btt", eng_btt, j.btt);
    chk("ready_held", req_ready, 0);
    if (j.btt != 0) begin
      chk("issue_en", eng_enable, 0);
      for (int k = 0; k < j.n_aw; k++) begin
        cyc();
        bvalid = 0; bready = 0; bresp = 2'b00;
        eng_new_transaction  = 1;
        eng_last_transaction = (k == j.n_aw - 1);
        #1 chk("aw_en", eng_enable, 1);
        cyc();
        eng_new_transaction  = 0;
        eng_last_transaction = 0;
        bvalid = 1; bready = 1;
        bresp  = (k == j.bad) ? 2'b10 : 2'b00;
        #1 chk("early_done", done, 0);
      end
      cyc();
      bvalid = 0; bready = 0; bresp = 2'b00;
    end
    #1;
    chk("done", done, oh);
    chk("err", err, j.exp_err ? oh : 4'b0);
    chk("done_ready", req_ready, 0);
    cyc();
    req_valid = '0;
  endtask

  initial begin
    jobs[0] = '{4'hF, 2'd0, 32'h0100, 23'd64, 1, -1, 1'b0};
    jobs[1] = '{4'hF, 2'd1, 32'h0200, 23'd64, 1, -1, 1'b0};
    jobs[2] = '{4'hF, 2'd2, 32'h0300, 23'd64, 1, -1, 1'b0};
    jobs[3] = '{4'hF, 2'd3, 32'h0400, 23'd64, 1, -1, 1'b0};
    jobs[4] = '{4'hF, 2'd0, 32'h0500, 23'd64, 1, -1, 1'b0};
    jobs[5] = '{4'h4, 2'd2, 32'h1000, 23'd4096, 4, -1, 1'b0};
    jobs[6] = '{4'h2, 2'd1, 32'h2000, 23'd300, 3, 1, 1'b1};
    jobs[7] = '{4'h2, 2'd1, 32'h3000, 23'd16, 1, -1, 1'b0};
    jobs[8] = '{4'h8, 2'd3, 32'h4000, 23'd0, 0, -1, 1'b0};
    jobs[9] = '{4'h9, 2'd0, 32'h5000, 23'd8, 2, -1, 1'b0};

    rst = 1; req_valid = '0; req_addr = '0; req_btt = '0;
    eng_new_transaction = 0; eng_last_transaction = 0;
    bvalid = 0; bready = 0; bresp = 2'b00;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_addr", eng_start_addr, 0);
    chk("rst_btt", eng_btt, 0);
    chk("rst_out", {done, err, req_ready, eng_start, eng_enable}, 0);
    rst = 0;
    cyc();

    for (int t = 0; t < 10; t++) run_job(jobs[t]);

    // Throttle: limit of 2 on u_thr, B held back
    set_slices(jobs[5]);
    req_valid = 4'h4;
    #1 chk("thr_ready", thr_ready, 4'h4);
    cyc();
    cyc();
    eng_new_transaction = 1;
    #1 chk("thr_en_0", thr_en, 1);
    cyc();
    #1 chk("thr_en_1", thr_en, 1);
    cyc();
    eng_new_transaction = 0;
    #1 chk("thr_full", thr_en, 0);
    chk("main_not_full", eng_enable, 1);
    cyc();
    bvalid = 1; bready = 1;
    #1 chk("thr_full_b", thr_en, 0);
    cyc();
    bvalid = 0; bready = 0;
    #1 chk("thr_free", thr_en, 1);
    eng_new_transaction  = 1;
    eng_last_transaction = 1;
    cyc();
    eng_new_transaction  = 0;
    eng_last_transaction = 0;
    bvalid = 1; bready = 1;
    cyc();
    cyc();
    bvalid = 0; bready = 0;
    #1 chk("thr_done", thr_done, 4'h4);
    chk("thr_main_done", done, 4'h4);
    cyc();
    req_valid = '0;

    // Reset with three AWs outstanding
    set_slices(jobs[9]);
    req_valid = 4'h1;
    cyc();
    cyc();
    eng_new_transaction = 1;
    cyc();
    cyc();
    cyc();
    eng_new_transaction = 0;
    #1 chk("pre_rst_busy", busy, 1);
    #1 rst = 1;
    #1 chk("rst_mid_busy", busy, 0);
    chk("rst_mid_en", eng_enable, 0);
    chk("rst_mid_out", {done, req_ready}, 0);
    cyc();
    chk("rst_mid_nodone", done, 0);
    rst = 0;
    req_valid = '0;
    cyc();
    run_job(jobs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
